// File: rtl/fetch_controller.sv
`default_nettype none
// ============================================================================
// Module   : fetch_controller
// Purpose  : Top-level sequencer for the single-cycle fetch datapath. Owns the
//            2-bit state consumed by the fetch stage, multiplexes the
//            instruction-memory port between host program loading and the
//            running PC, detects program termination and keeps run/load
//            statistics for the host.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   HALT_WORD   : IR value that terminates a run
//   MAX_CYCLES  : RUN-cycle budget before forced halt (timeout build only)
// Build option
//   FETCH_CTRL_TIMEOUT_EN : when defined, the MAX_CYCLES budget is enforced
//                           and `timeout` reports budget exhaustion; when
//                           undefined, `timeout` is tied low.
// Ports
//   clk         in   1 : clock, all state updates on rising edge
//   rst         in   1 : synchronous active-low reset
//   start       in   1 : launch a run from IDLE / acknowledge HALT
//   host_we     in   1 : host write strobe for instruction memory
//   haddr       in   8 : host word address
//   hdin        in  32 : host write data
//   pc          in  32 : PC from the fetch stage
//   ir          in  32 : IR from the fetch stage
//   curr_state  out  2 : IDLE 00, RUN 01, LOAD 10, HALT 11
//   im_wea      out  1 : instruction-memory write enable
//   im_addr     out  8 : instruction-memory word address
//   im_din      out 32 : instruction-memory write data
//   load_count  out  9 : words written in the current load session
//   cycle_count out 32 : RUN cycles in the current/last run
//   done        out  1 : high in HALT
//   timeout     out  1 : last run ended by budget exhaustion
// ============================================================================
module fetch_controller #(
  parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF,
  parameter int unsigned MAX_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        host_we,
  input  logic [7:0]  haddr,
  input  logic [31:0] hdin,
  input  logic [31:0] pc,
  input  logic [31:0] ir,
  output logic [1:0]  curr_state,
  output logic        im_wea,
  output logic [7:0]  im_addr,
  output logic [31:0] im_din,
  output logic [8:0]  load_count,
  output logic [31:0] cycle_count,
  output logic        done,
  output logic        timeout
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_LOAD = 2'b10,
    ST_HALT = 2'b11
  } state_e;

  localparam logic [8:0]  c_load_max  = 9'd256;
  localparam logic [31:0] c_cycle_max = 32'hFFFF_FFFF;

  state_e      state_q, state_d;
  logic [8:0]  load_count_q, load_count_d;
  logic [31:0] cycle_count_q, cycle_count_d;

  logic        w_halt_hit;
  logic        w_budget_hit;

  // IR lags PC by one cycle and PC restarts at 0, so during the first two
  // RUN cycles IR may still hold the halt word from the previous run.
  assign w_halt_hit = (ir == HALT_WORD) && (cycle_count_q >= 32'd2);

`ifdef FETCH_CTRL_TIMEOUT_EN
  localparam logic [31:0] c_budget_last = 32'(MAX_CYCLES - 1);

  logic timeout_q, timeout_d;

  assign w_budget_hit = (cycle_count_q == c_budget_last);
  assign timeout      = timeout_q;
`else
  logic w_unused_cfg;

  // Without the budget the cycle limit has no consumer.
  assign w_unused_cfg = ^{32'(MAX_CYCLES)};
  assign w_budget_hit = 1'b0;
  assign timeout      = 1'b0;
`endif

  // Only the word-address bits of the PC drive the memory port.
  logic w_unused_pc;
  assign w_unused_pc = ^{pc[31:10], pc[1:0]};

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      load_count_q  <= 9'd0;
      cycle_count_q <= 32'd0;
`ifdef FETCH_CTRL_TIMEOUT_EN
      timeout_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      load_count_q  <= load_count_d;
      cycle_count_q <= cycle_count_d;
`ifdef FETCH_CTRL_TIMEOUT_EN
      timeout_q     <= timeout_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and counter logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    load_count_d  = load_count_q;
    cycle_count_d = cycle_count_q;
`ifdef FETCH_CTRL_TIMEOUT_EN
    timeout_d     = timeout_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        // A host write wins over start so a program load is never lost.
        if (host_we) begin
          state_d      = ST_LOAD;
          load_count_d = 9'd1;
        end else if (start) begin
          state_d       = ST_RUN;
          cycle_count_d = 32'd0;
`ifdef FETCH_CTRL_TIMEOUT_EN
          timeout_d     = 1'b0;
`endif
        end
      end

      ST_LOAD: begin
        if (host_we) begin
          if (load_count_q != c_load_max) begin
            load_count_d = load_count_q + 9'd1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        if (cycle_count_q != c_cycle_max) begin
          cycle_count_d = cycle_count_q + 32'd1;
        end
        if (w_halt_hit) begin
          state_d = ST_HALT;
        end else if (w_budget_hit) begin
          state_d = ST_HALT;
`ifdef FETCH_CTRL_TIMEOUT_EN
          timeout_d = 1'b1;
`endif
        end
      end

      ST_HALT: begin
        if (start) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign curr_state  = state_q;
  assign load_count  = load_count_q;
  assign cycle_count = cycle_count_q;
  assign done        = (state_q == ST_HALT);

  // The memory port belongs to the PC while running, to the host otherwise.
  // Gating with rst keeps the memory untouched in a reset cycle.
  assign im_wea  = host_we & rst & ((state_q == ST_IDLE) | (state_q == ST_LOAD));
  assign im_addr = (state_q == ST_RUN) ? pc[9:2] : haddr;
  assign im_din  = hdin;

endmodule
`default_nettype wire

// File: tb/tb_fetch_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_controller
// Purpose  : Self-checking bench for fetch_controller. A behavioural model of
//            the sequencing rules is compared against the DUT every cycle;
//            directed phases follow the program load / halt / restart /
//            timeout scenarios, then randomized traffic is applied.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_controller;

  localparam logic [31:0] HALT_WORD  = 32'hFFFF_FFFF;
  localparam int          MAX_CYCLES = 10;
`ifdef FETCH_CTRL_TIMEOUT_EN
  localparam bit          TO_EN      = 1'b1;
`else
  localparam bit          TO_EN      = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, start, host_we;
  logic [7:0]  haddr;
  logic [31:0] hdin, pc, ir;
  logic [1:0]  curr_state;
  logic        im_wea;
  logic [7:0]  im_addr;
  logic [31:0] im_din;
  logic [8:0]  load_count;
  logic [31:0] cycle_count;
  logic        done, timeout;

  // Environment: a fetch stage and an instruction memory fed by the DUT port.
  logic        fetch_mode;
  logic [31:0] r_pc, r_ir;
  logic [31:0] f_pc = 32'd0;
  logic [31:0] f_ir = 32'd0;
  logic [31:0] dut_mem [256];

  assign pc = fetch_mode ? f_pc : r_pc;
  assign ir = fetch_mode ? f_ir : r_ir;

  fetch_controller #(
    .HALT_WORD  (HALT_WORD),
    .MAX_CYCLES (MAX_CYCLES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .host_we     (host_we),
    .haddr       (haddr),
    .hdin        (hdin),
    .pc          (pc),
    .ir          (ir),
    .curr_state  (curr_state),
    .im_wea      (im_wea),
    .im_addr     (im_addr),
    .im_din      (im_din),
    .load_count  (load_count),
    .cycle_count (cycle_count),
    .done        (done),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (im_wea) dut_mem[im_addr] <= im_din;
    if (curr_state == 2'b01) begin
      f_ir <= dut_mem[f_pc[9:2]];
      f_pc <= f_pc + 32'd4;
    end else begin
      f_pc <= 32'd0;
    end
  end

  // --------------------------------------------------------------------------
  // Behavioural model (states: 0 idle, 1 run, 2 load, 3 halt)
  // --------------------------------------------------------------------------
  int          m_st = 0;
  int          m_lc = 0;
  logic [31:0] m_cc = 32'd0;
  bit          m_to = 1'b0;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin
    if (!rst) begin
      m_st = 0; m_lc = 0; m_cc = 32'd0; m_to = 1'b0;
      chk_en = 1'b1;
    end else if (chk_en) begin
      if (m_st == 0) begin
        if (host_we) begin
          m_st = 2; m_lc = 1;
        end else if (start) begin
          m_st = 1; m_cc = 32'd0; m_to = 1'b0;
        end
      end else if (m_st == 2) begin
        if (host_we) m_lc = (m_lc >= 256) ? 256 : m_lc + 1;
        else         m_st = 0;
      end else if (m_st == 1) begin
        bit stop_halt, stop_budget;
        stop_halt   = (ir == HALT_WORD) && (m_cc >= 2);
        stop_budget = TO_EN && (m_cc == 32'(MAX_CYCLES - 1));
        if (stop_halt) m_st = 3;
        else if (stop_budget) begin m_st = 3; m_to = 1'b1; end
        if (m_cc != 32'hFFFF_FFFF) m_cc = m_cc + 32'd1;
      end else begin
        if (start) m_st = 0;
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare process: outputs sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("curr_state",  32'(curr_state),  32'(m_st));
      chk("load_count",  32'(load_count),  32'(m_lc));
      chk("cycle_count", cycle_count,      m_cc);
      chk("timeout",     32'(timeout),     32'(m_to));
      chk("done",        32'(done),        32'(m_st == 3));
      chk("im_wea",      32'(im_wea),      32'(host_we && rst && (m_st == 0 || m_st == 2)));
      chk("im_addr",     32'(im_addr),     32'((m_st == 1) ? pc[9:2] : haddr));
      chk("im_din",      im_din,           hdin);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] prog [4];

  initial begin
    prog[0] = 32'h11; prog[1] = 32'h22; prog[2] = 32'h33; prog[3] = HALT_WORD;
    fetch_mode = 1'b1;
    r_pc = 32'd0; r_ir = 32'd0;

    // Reset with start and host_we asserted.
    rst = 1'b0; start = 1'b1; host_we = 1'b1; haddr = 8'd5; hdin = 32'hABCD;
    cyc(); cyc();
    chk("reset state",  32'(curr_state), 32'd0);
    chk("reset lc",     32'(load_count), 32'd0);
    chk("reset cc",     cycle_count,     32'd0);
    chk("reset to",     32'(timeout),    32'd0);
    chk("reset im_wea", 32'(im_wea),     32'd0);

    // Load the four-word program.
    rst = 1'b1; start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      haddr = 8'(i); hdin = prog[i]; host_we = 1'b1;
      cyc();
    end
    chk("load state", 32'(curr_state), 32'd2);
    chk("load lc",    32'(load_count), 32'd4);
    host_we = 1'b0;
    cyc();
    chk("load exit", 32'(curr_state), 32'd0);
    for (int i = 0; i < 4; i++) chk("load mem", dut_mem[i], prog[i]);

    // Halt run.
    start = 1'b1; cyc(); start = 1'b0;
    chk("run entry", 32'(curr_state), 32'd1);
    repeat (5) cyc();
    chk("halt state", 32'(curr_state), 32'd3);
    chk("halt cc",    cycle_count,     32'd5);
    chk("halt done",  32'(done),       32'd1);
    chk("halt to",    32'(timeout),    32'd0);
    repeat (2) cyc();
    chk("halt hold cc", cycle_count, 32'd5);

    // Restart with start held: HALT -> IDLE -> RUN, stale halt IR masked.
    start = 1'b1; cyc();
    chk("restart idle", 32'(curr_state), 32'd0);
    cyc();
    chk("restart run", 32'(curr_state), 32'd1);
    chk("restart cc",  cycle_count,     32'd0);
    start = 1'b0; cyc();
    chk("stale ir masked", 32'(curr_state), 32'd1);
    repeat (4) cyc();
    chk("rehalt state", 32'(curr_state), 32'd3);
    chk("rehalt cc",    cycle_count,     32'd5);
    start = 1'b1; cyc();

    // host_we beats start in IDLE; start ignored in LOAD.
    host_we = 1'b1; haddr = 8'd10; hdin = 32'h5A5A; cyc();
    chk("we beats start", 32'(curr_state), 32'd2);
    chk("we beats lc",    32'(load_count), 32'd1);
    host_we = 1'b0; cyc();
    chk("load ignores start", 32'(curr_state), 32'd0);
    cyc(); start = 1'b0;
    chk("run again", 32'(curr_state), 32'd1);
    host_we = 1'b1; haddr = 8'd0; hdin = 32'd0;
    cyc(); cyc();
    chk("run ignores we lc", 32'(load_count), 32'd1);
    chk("run ignores we st", 32'(curr_state), 32'd1);
    rst = 1'b0; cyc();
    chk("mid-run reset", 32'(curr_state), 32'd0);
    chk("mid-run reset cc", cycle_count, 32'd0);
    chk("no write in run", dut_mem[0], 32'h11);
    rst = 1'b1; host_we = 1'b0;

    // Fill memory without a halt word; 260 writes saturate load_count.
    for (int i = 0; i < 260; i++) begin
      host_we = 1'b1; haddr = 8'(i); hdin = 32'(i + 100);
      cyc();
    end
    chk("lc saturate", 32'(load_count), 32'd256);
    chk("addr wrap", dut_mem[3], 32'd359);
    host_we = 1'b0; cyc();
    start = 1'b1; cyc(); start = 1'b0;
`ifdef FETCH_CTRL_TIMEOUT_EN
    repeat (9) cyc();
    chk("budget not yet", 32'(curr_state), 32'd1);
    cyc();
    chk("budget halt",  32'(curr_state), 32'd3);
    chk("budget to",    32'(timeout),    32'd1);
    chk("budget cc",    cycle_count,     32'd10);
    start = 1'b1; cyc();
    chk("to holds in idle", 32'(timeout), 32'd1);
    cyc();
    chk("to cleared on start", 32'(timeout), 32'd0);
    start = 1'b0;
`else
    repeat (100) cyc();
    chk("no budget state", 32'(curr_state), 32'd1);
    chk("no budget cc",    cycle_count,     32'd100);
    chk("no budget to",    32'(timeout),    32'd0);
`endif
    rst = 1'b0; cyc(); rst = 1'b1;

    // Randomized traffic with free-running PC/IR.
    fetch_mode = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 49) != 0);
      start   = ($urandom_range(0, 3) == 0);
      host_we = ($urandom_range(0, 2) == 0);
      haddr   = 8'($urandom);
      hdin    = $urandom;
      r_pc    = $urandom;
      r_ir    = ($urandom_range(0, 2) == 0) ? HALT_WORD : $urandom;
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
